// File: rtl/display_scan_mux_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package display_pkg;
    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 16;

    // Board defaults for a 100 MHz clock: 1 ms per digit slot and 250 ms blink half-period.
    localparam int DEF_NUM_DIGITS  = 4;
    localparam int DEF_REFRESH_DIV = 100000;
    localparam int DEF_GUARD       = 2;
    localparam int DEF_BLINK_TICKS = 250;

    // Active-low one-hot anode pattern. The caller narrows it to its digit count.
    function automatic logic [MAX_DIGITS-1:0] anode_pattern(input int unsigned idx);
        return ~(MAX_DIGITS'(1) << idx);
    endfunction
endpackage

// File: rtl/display_scan_mux_if.sv
// Digit data in, decoder nibble, anodes and slot tick out.
interface display_scan_mux_if #(parameter int NUM_DIGITS = 4);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blink_en;
    logic [3:0]              nibble;
    logic [NUM_DIGITS-1:0]   an;
    logic                    scan_tick;

    modport master (output value, digit_en, blink_en, input nibble, an, scan_tick);
    modport slave  (input value, digit_en, blink_en, output nibble, an, scan_tick);
endinterface

// File: rtl/display_scan_mux_tick_divider.sv
// Modulo-N counter. The terminal-count pulse is high while enabled and at N-1.
module tick_divider #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         tc
);
    assign tc = en && (count == W'(N - 1));

    // Count enabled events. Wrap at N-1. A synchronous clear holds the count at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     count <= '0;
        else if (clr)   count <= '0;
        else if (en)    count <= tc ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/display_scan_mux.sv
// Scans a packed hex value across a common-anode display, with guard time,
// per-digit blanking and whole-display blink. All outputs are registered.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int GUARD       = DEF_GUARD,
    parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
    input logic clk,
    input logic rst_n,
    display_scan_mux_if.slave bus
);
    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SW-1:0]               slot_cnt;
    logic                        slot_tc;
    logic                        blink_tc;
    logic [IW-1:0]               idx;
    logic [DIGIT_W*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]       shadow_mask;
    logic                        phase;
    logic                        lit;

    tick_divider #(.N(REFRESH_DIV), .W(SW)) u_slot (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0),
        .count(slot_cnt), .tc(slot_tc)
    );

    // Blink counter advances once per slot. It is held at zero while blinking is off.
    tick_divider #(.N(BLINK_TICKS), .W(BW)) u_blink (
        .clk(clk), .rst_n(rst_n), .en(slot_tc & bus.blink_en), .clr(~bus.blink_en),
        .count(), .tc(blink_tc)
    );

    // Digit index advances each slot. Inputs are snapshotted only at frame wrap,
    // so the frame in progress never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            shadow_value <= '0;
            shadow_mask  <= '0;
        end else if (slot_tc) begin
            if (idx == IW'(NUM_DIGITS - 1)) begin
                idx          <= '0;
                shadow_value <= bus.value;
                shadow_mask  <= bus.digit_en;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Blink phase: 0 = lit, 1 = dark. Forced back to lit as soon as blinking stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             phase <= 1'b0;
        else if (!bus.blink_en) phase <= 1'b0;
        else if (blink_tc)      phase <= ~phase;
    end

    // blink_en is gated in directly so that dropping it relights on the next cycle.
    assign lit = (int'(slot_cnt) >= GUARD) && shadow_mask[idx] && !(bus.blink_en && phase);

    // Registered outputs, one cycle behind the counter and index state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an        <= '1;
            bus.nibble    <= '0;
            bus.scan_tick <= 1'b0;
        end else begin
            bus.an        <= lit ? NUM_DIGITS'(anode_pattern(int'(idx))) : '1;
            bus.nibble    <= shadow_value[DIGIT_W*idx +: DIGIT_W];
            bus.scan_tick <= slot_tc;
        end
    end
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, BLINK_TICKS=4.
module tb_display_scan_mux;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ecount   = 0;   // rising edges since reset release

    logic [3:0] an_tab   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] nib_1234 [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] nib_abcd [4] = '{4'hD, 4'hC, 4'hB, 4'hA};
    logic [3:0] nib_0042 [4] = '{4'h2, 4'h4, 4'h0, 4'h0};

    display_scan_mux_if #(.NUM_DIGITS(4)) bus ();

    display_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .BLINK_TICKS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    // Hold reset, release, and expect a dark display until the first frame capture.
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.an !== 4'b1111 || bus.nibble !== 4'h0 || bus.scan_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold an=%b nibble=%h tick=%b want 1111/0/0", bus.an, bus.nibble, bus.scan_tick);
            end
        end
        rst_n  = 1'b1;
        ecount = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            n_checks++;
            if (bus.an !== 4'b1111 || bus.nibble !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_dark e=%0d an=%b nibble=%h want 1111/0", ecount, bus.an, bus.nibble);
            end
            n_checks++;
            if (bus.scan_tick !== (ecount % 8 == 0)) begin
                n_fail++;
                $display("FAIL reset_tick e=%0d got %b want %b", ecount, bus.scan_tick, (ecount % 8 == 0));
            end
        end
    endtask

    // First lit frame: 1234 with all digits enabled.
    task automatic test_scan();
        for (int k = 0; k < 32; k++) begin
            int s, c;
            logic [3:0] exp_an;
            tick();
            s = ((ecount - 1) / 8) % 4;
            c = (ecount - 1) % 8;
            exp_an = (c < 2) ? 4'b1111 : an_tab[s];
            n_checks++;
            if (bus.nibble !== nib_1234[s] || bus.an !== exp_an) begin
                n_fail++;
                $display("FAIL scan e=%0d nibble=%h an=%b want %h/%b", ecount, bus.nibble, bus.an, nib_1234[s], exp_an);
            end
            n_checks++;
            if (bus.scan_tick !== (ecount % 8 == 0)) begin
                n_fail++;
                $display("FAIL scan_tick e=%0d got %b want %b", ecount, bus.scan_tick, (ecount % 8 == 0));
            end
        end
    endtask

    // A value change mid-frame only shows up in the following frame.
    task automatic test_midframe_change();
        for (int k = 0; k < 64; k++) begin
            int s, c;
            logic [3:0] exp_an, exp_nib;
            tick();
            s = ((ecount - 1) / 8) % 4;
            c = (ecount - 1) % 8;
            exp_an  = (c < 2) ? 4'b1111 : an_tab[s];
            exp_nib = (ecount <= 96) ? nib_1234[s] : nib_abcd[s];
            n_checks++;
            if (bus.nibble !== exp_nib || bus.an !== exp_an) begin
                n_fail++;
                $display("FAIL midframe e=%0d nibble=%h an=%b want %h/%b", ecount, bus.nibble, bus.an, exp_nib, exp_an);
            end
            if (ecount == 75) bus.value = 16'hABCD;
        end
    endtask

    // Blanked upper digits stay dark while nibble still cycles through them.
    task automatic test_digit_en();
        bus.value    = 16'h0042;
        bus.digit_en = 4'b0011;
        repeat (32) tick();
        for (int k = 0; k < 32; k++) begin
            int s, c;
            logic [3:0] exp_an;
            tick();
            s = ((ecount - 1) / 8) % 4;
            c = (ecount - 1) % 8;
            exp_an = (c < 2 || s >= 2) ? 4'b1111 : an_tab[s];
            n_checks++;
            if (bus.nibble !== nib_0042[s] || bus.an !== exp_an) begin
                n_fail++;
                $display("FAIL digit_en e=%0d nibble=%h an=%b want %h/%b", ecount, bus.nibble, bus.an, nib_0042[s], exp_an);
            end
            if (ecount == 190) begin
                bus.value    = 16'h1234;
                bus.digit_en = 4'hF;
            end
        end
    endtask

    // Blink: 4 slots lit, 4 dark, repeating. Dropping blink_en relights on the next cycle.
    task automatic test_blink();
        bus.blink_en = 1'b1;
        for (int k = 0; k < 128; k++) begin
            int s, c;
            logic dark;
            logic [3:0] exp_an;
            tick();
            s = ((ecount - 1) / 8) % 4;
            c = (ecount - 1) % 8;
            dark = (ecount >= 225 && ecount <= 256) || (ecount >= 289 && ecount <= 300);
            exp_an = (dark || c < 2) ? 4'b1111 : an_tab[s];
            n_checks++;
            if (bus.an !== exp_an || bus.nibble !== nib_1234[s]) begin
                n_fail++;
                $display("FAIL blink e=%0d an=%b nibble=%h want %b/%h", ecount, bus.an, bus.nibble, exp_an, nib_1234[s]);
            end
            if (ecount == 300) bus.blink_en = 1'b0;
        end
    endtask

    // Asynchronous reset while a digit is lit darkens the display without a clock edge.
    task automatic test_reset_midscan();
        for (int k = 0; k < 12; k++) tick();
        n_checks++;
        if (bus.an !== 4'b1101) begin
            n_fail++;
            $display("FAIL pre_reset_an e=%0d got %b want 1101", ecount, bus.an);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.an !== 4'b1111 || bus.nibble !== 4'h0 || bus.scan_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset an=%b nibble=%h tick=%b want 1111/0/0", bus.an, bus.nibble, bus.scan_tick);
        end
        test_reset();
    endtask

    // Random inputs: never more than one anode low, and never during the guard cycles.
    task automatic test_random();
        for (int k = 0; k < 1000; k++) begin
            int c;
            tick();
            c = (ecount - 1) % 8;
            n_checks++;
            if ($countones(~bus.an) > 1) begin
                n_fail++;
                $display("FAIL one_hot e=%0d an=%b want at most one low", ecount, bus.an);
            end
            n_checks++;
            if (bus.an !== 4'b1111 && c < 2) begin
                n_fail++;
                $display("FAIL guard e=%0d an=%b slot_cnt=%0d want 1111", ecount, bus.an, c);
            end
            bus.value    = 16'($urandom);
            bus.digit_en = 4'($urandom);
            bus.blink_en = 1'($urandom);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.value    = 16'h1234;
        bus.digit_en = 4'hF;
        bus.blink_en = 1'b0;
        test_reset();
        test_scan();
        test_midframe_change();
        test_digit_en();
        test_blink();
        test_reset_midscan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
